// File: rtl/counter_load_ctrl.sv
// Sequencer for a 4-bit loadable counter: runs accepted jobs from start to end
// for a number of periods (or forever), freezing the counter whenever idle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | counter frozen by reloading count_i; ready for a job
// LOAD    | load start value into the counter
// RUN     | counter free-runs; terminal match wraps or finishes the job
// DONE    | one-cycle completion pulse, counter held at end value
module counter_load_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_auto,
    input  logic             abort,
    input  logic [WIDTH-1:0] count_i,
    output logic             load,
    output logic [WIDTH-1:0] load_data,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] end_r;
    logic [REP_W-1:0] reps_left;
    logic             auto_r;

    logic match;
    logic last_period;
    logic accept;
    logic reps_dec;

    assign match       = (state == ST_RUN) && (count_i == end_r);
    assign last_period = !auto_r && (reps_left == REP_W'(1));
    assign accept      = (state == ST_IDLE) && cfg_valid && !abort;
    // Zero reps decrements to all-ones, which is how 0 stands for 2^REP_W.
    assign reps_dec    = match && !abort && !auto_r;

    always_comb begin
        state_nxt = state;
        load      = 1'b1;
        load_data = count_i;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        wrap      = 1'b0;
        done      = 1'b0;
        if (reset) begin
            cfg_ready = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    cfg_ready = !abort;
                    if (accept) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    busy = 1'b1;
                    if (abort) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        load_data = start_r;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    busy = 1'b1;
                    if (abort) begin
                        state_nxt = ST_IDLE;
                    end else if (match) begin
                        wrap = 1'b1;
                        if (last_period) begin
                            state_nxt = ST_DONE;
                        end else begin
                            load_data = start_r;
                        end
                    end else begin
                        load = 1'b0;
                    end
                end
                default: begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            start_r   <= '0;
            end_r     <= '0;
            reps_left <= '0;
            auto_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                start_r   <= cfg_start;
                end_r     <= cfg_end;
                reps_left <= cfg_reps;
                auto_r    <= cfg_auto;
            end else if (reps_dec) begin
                reps_left <= reps_left - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Bench for counter_load_ctrl: a behavioural counter drives count_i, and a
// job-schedule model predicts every output from elapsed cycles since accept.
module tb_counter_load_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_auto = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_start = 4'd0;
    logic [3:0] cfg_end = 4'd0;
    logic [3:0] cfg_reps = 4'd0;
    logic [3:0] count_i = 4'd7;
    logic       cfg_ready;
    logic       load;
    logic [3:0] load_data;
    logic       busy;
    logic       wrap;
    logic       done;

    always #5 clk = ~clk;

    counter_load_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_end   (cfg_end),
        .cfg_reps  (cfg_reps),
        .cfg_auto  (cfg_auto),
        .abort     (abort),
        .count_i   (count_i),
        .load      (load),
        .load_data (load_data),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    // the loadable counter being sequenced
    always @(posedge clk) count_i <= load ? load_data : count_i + 4'd1;

    int n_chk = 0;
    int n_err = 0;

    // job model: rel 0 = load cycle, 1..last = run cycles, last+1 = done cycle
    bit m_job = 1'b0;
    int m_rel = 0;
    int m_last = 0;
    int m_start = 0;
    int m_p = 1;
    int m_hold = 7;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit match_pending();
        return m_job && m_rel >= 1 && m_rel <= m_last && (m_rel % m_p) == 0;
    endfunction

    task automatic eval_cycle();
        int e_cnt, e_load, e_ld, e_ready, e_busy, e_wrap, e_done;
        int n;
        bit run;
        run     = m_job && m_rel >= 1 && m_rel <= m_last;
        e_cnt   = run ? (m_start + (m_rel - 1) % m_p) % 16 : m_hold;
        e_load  = 1;
        e_ld    = e_cnt;
        e_ready = 0;
        e_busy  = 0;
        e_wrap  = 0;
        e_done  = 0;
        if (reset) begin
            e_ready = 1;
        end else if (!m_job) begin
            e_ready = !abort;
        end else if (m_rel == 0) begin
            e_busy = 1;
            if (!abort) e_ld = m_start;
        end else if (run) begin
            e_busy = 1;
            if (!abort) begin
                e_wrap = ((m_rel % m_p) == 0);
                e_load = e_wrap;
                if (e_wrap && m_rel != m_last) e_ld = m_start;
            end
        end else begin
            e_done = 1;
        end

        check_val("count", count_i, e_cnt);
        check_val("load", load, e_load);
        if (e_load == 1) check_val("load_data", load_data, e_ld);
        check_val("cfg_ready", cfg_ready, e_ready);
        check_val("busy", busy, e_busy);
        check_val("wrap", wrap, e_wrap);
        check_val("done", done, e_done);

        if (reset) begin
            m_job = 1'b0;
        end else if (!m_job) begin
            if (cfg_valid && !abort) begin
                m_job   = 1'b1;
                m_rel   = 0;
                m_start = cfg_start;
                m_p     = ((int'(cfg_end) - int'(cfg_start)) & 15) + 1;
                n       = (cfg_reps == 4'd0) ? 16 : int'(cfg_reps);
                m_last  = cfg_auto ? (1 << 30) : n * m_p;
            end
        end else if (m_rel <= m_last && abort) begin
            m_job = 1'b0;
        end else if (m_rel == m_last + 1) begin
            m_job = 1'b0;
        end else begin
            m_rel++;
        end
        m_hold = e_cnt;
    endtask

    task automatic step(input bit v, input int s, input int e, input int r,
                        input bit a, input bit ab, input bit rs);
        @(posedge clk);
        #1;
        reset     = rs;
        cfg_valid = v;
        cfg_start = 4'(s);
        cfg_end   = 4'(e);
        cfg_reps  = 4'(r);
        cfg_auto  = a;
        abort     = ab;
        @(negedge clk);
        eval_cycle();
    endtask

    task automatic idle_step();
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to_idle(input int max_cyc);
        int k;
        k = 0;
        while (m_job && k < max_cyc) begin
            idle_step();
            k++;
        end
        check_val("job_timeout", int'(m_job), 0);
    endtask

    initial begin
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle_step();
        check_val("reset_hold7", count_i, 7);

        step(1'b1, 3, 6, 2, 1'b0, 1'b0, 1'b0);
        run_to_idle(40);
        idle_step();
        check_val("job1_end", count_i, 6);

        step(1'b1, 14, 1, 1, 1'b0, 1'b0, 1'b0);
        run_to_idle(40);
        idle_step();
        check_val("wrap_end", count_i, 1);

        step(1'b1, 9, 9, 0, 1'b0, 1'b0, 1'b0);
        run_to_idle(40);
        idle_step();

        step(1'b1, 0, 2, 5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) idle_step();
        for (int i = 0; i < 6; i++) begin
            if (match_pending()) begin
                step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
                break;
            end
            idle_step();
        end
        check_val("auto_aborted", int'(m_job), 0);
        idle_step();
        check_val("abort_hold2", count_i, 2);
        check_val("abort_ready", cfg_ready, 1);

        step(1'b1, 5, 7, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12 && m_job; i++) step(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        check_val("second_accepted", int'(m_job), 1);
        run_to_idle(40);
        idle_step();
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);

        for (int j = 0; j < 40; j++) begin
            int s, e, r, k;
            bit a;
            s = $urandom_range(0, 15);
            e = $urandom_range(0, 15);
            r = $urandom_range(0, 15);
            a = ($urandom_range(0, 5) == 0);
            step(1'b1, s, e, r, a, 1'b0, 1'b0);
            k = 0;
            while (m_job && k < 600) begin
                bit ab, rs, v;
                ab = ($urandom_range(0, 59) == 0) || (a && k > 80);
                rs = ($urandom_range(0, 299) == 0);
                v  = ($urandom_range(0, 3) == 0);
                step(v, $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), 1'b0, ab, rs);
                k++;
            end
            check_val("rand_timeout", int'(m_job), 0);
            step(1'b0, 0, 0, 0, 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_load_ctrl.md
Name: counter_load_ctrl

Overview:
- Upstream sequencer for the 4-bit loadable counter. It drives the counter's load/load_data pins and watches its count output.
- Each accepted job runs the counter from a start value to an end value for a programmed number of periods, or forever in auto-reload mode.
- When not running, it freezes the counter by reloading the current count every cycle.
- It signals each wrap and the end of each job to the surrounding control logic.

Parameters:
WIDTH, 4, counter width; applies to count_i, load_data, cfg_start and cfg_end.
REP_W, 4, width of cfg_reps and of the internal remaining-periods counter.

Ports:
clk  input  1  rising-edge clock, shared with the counter.
reset  input  1  synchronous, active-high reset.
cfg_valid  input  1  job request.
cfg_ready  output  1  controller can accept a job.
cfg_start  input  WIDTH  value loaded at the start of each period.
cfg_end  input  WIDTH  terminal value of each period.
cfg_reps  input  REP_W  number of periods; 0 means 2^REP_W.
cfg_auto  input  1  1 = reload indefinitely and ignore cfg_reps.
abort  input  1  cancel the running job.
count_i  input  WIDTH  counter output.
load  output  1  counter load strobe.
load_data  output  WIDTH  counter load value.
busy  output  1  job in progress (LOAD or RUN).
wrap  output  1  one-cycle pulse on each terminal match.
done  output  1  one-cycle pulse when a job completes normally.

Behaviour:
- One clock. Reset is synchronous and active-high, on port reset; it overrides all other inputs.
- Reset values: state=IDLE, start_r=end_r=0, reps_left=0, auto_r=0. While reset is high, outputs decode as IDLE: load=1, load_data=count_i, cfg_ready=1, busy=0, wrap=0, done=0.
- Outputs are combinational decodes of state, the job registers and count_i.
- Counter timing: if load=1 in cycle N, count_i=load_data in cycle N+1. If load=0, count_i increments mod 2^WIDTH.
- States:
  - IDLE:
    - Outputs: load=1, load_data=count_i (hold), cfg_ready = ~abort.
    - On cfg_valid & cfg_ready: capture start_r, end_r, auto_r; reps_left = cfg_reps. Next state LOAD.
  - LOAD:
    - Outputs: load=1, load_data=start_r, busy=1, cfg_ready=0. Next state RUN.
  - RUN:
    - Outputs: busy=1, cfg_ready=0. load=0 unless a terminal match occurs.
    - Terminal match (count_i==end_r): wrap=1.
    - On a match with auto_r=1, or reps_left != 1: load=1, load_data=start_r, stay in RUN. If auto_r=0, decrement reps_left mod 2^REP_W; this makes 0 act as 2^REP_W.
    - On a match with auto_r=0 and reps_left==1: load=1, load_data=count_i (hold at end). Next state DONE.
  - DONE:
    - Outputs: done=1, load=1, load_data=count_i, busy=0, cfg_ready=0. Next state IDLE.
- Period length: d+1 cycles, where d=(end_r−start_r) mod 2^WIDTH. If start==end, every RUN cycle is a match, so each period is 1 cycle.
- First match occurs d+1 cycles after the LOAD cycle.
- Abort:
  - abort=1 in LOAD or RUN: load=1, load_data=count_i, wrap=0, done=0; next state IDLE; no done pulse.
  - Abort takes priority over a simultaneous terminal match.
  - abort in IDLE or DONE: no effect, except that cfg_ready is forced low in IDLE.
- cfg_valid outside IDLE is ignored, with no capture. Jobs are not queued.
- Terminal match is checked only in RUN. Matches in LOAD, DONE or IDLE produce no wrap.
- Reset asserted mid-job: next cycle is IDLE with no done; the counter holds its value unless its own reset_n is asserted.
- Back-to-back jobs: the earliest next accept is the IDLE cycle following DONE.

Test Plan:
- Reset high 2 cycles with count_i=7 → load=1, load_data=7, cfg_ready=1, busy=0; count stays 7.
- Job start=3, end=6, reps=2, auto=0 → count sequence 3,4,5,6,3,4,5,6. wrap pulses at both 6s. count holds 6, done pulses 1 cycle later, then IDLE.
- Wrap-around: start=14, end=1, reps=1 → count 14,15,0,1. One wrap, then done; count holds 1.
- start=end=9, reps=0 (=16 periods) → 16 consecutive wrap pulses with count=9 throughout, then done.
- auto=1, start=0, end=2 → wrap every 3 cycles for ≥20 cycles; abort raised in a match cycle → no wrap, no done, count holds 2, IDLE, cfg_ready=1.
- cfg_valid held high during RUN with different fields → ignored; the job finishes with its original values, and the new request is accepted the cycle after DONE.
